// File: rtl/spectrum_column_writer.sv
`default_nettype none
// ============================================================================
// Module   : spectrum_column_writer
// Purpose  : Turns STFT bins into 8-bit log-magnitude pixels with peak-hold
//            and decay, and writes one framebuffer column per emitted sweep.
// Revision : 1.0  initial release
// ============================================================================
module spectrum_column_writer #(
  parameter int WORD_WIDTH = 16,
  parameter int FFT_SIZE   = 256,
  parameter int NUM_COLS   = 128,
  parameter int DECIMATE   = 64,
  parameter int DECAY      = 4
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           in_valid,
  input  logic [$clog2(FFT_SIZE)-1:0]                    in_idx,
  input  logic [2*WORD_WIDTH-1:0]                        in_data,
  input  logic                                           freeze,
  output logic                                           pix_wr_en,
  output logic [$clog2(NUM_COLS)+$clog2(FFT_SIZE)-2:0]   pix_wr_addr,
  output logic [7:0]                                     pix_wr_data,
  output logic                                           column_done,
  output logic [$clog2(NUM_COLS)-1:0]                    col_idx
);
  localparam int W      = WORD_WIDTH;
  localparam int IDX_W  = $clog2(FFT_SIZE);
  localparam int BIN_W  = IDX_W - 1;
  localparam int COL_W  = $clog2(NUM_COLS);
  localparam int NBINS  = FFT_SIZE / 2;
  localparam int SC_W   = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam logic [BIN_W-1:0] C_LAST_BIN = BIN_W'(NBINS - 1);
  localparam logic [SC_W-1:0]  C_SC_LAST  = SC_W'(DECIMATE - 1);
  localparam logic [7:0]       C_DECAY    = 8'(DECAY);
  localparam logic [3:0]       C_TOP      = 4'(W - 1);

  logic               r_s1_v, r_s2_v, r_s3_v;
  logic [BIN_W-1:0]   r_s1_bin, r_s2_bin, r_s3_bin;
  logic [W-1:0]       r_s1_are, r_s1_aim, r_s2_mag;
  logic [7:0]         r_s1_peak, r_s2_peak, r_s3_peak, r_s3_code;
  logic [NBINS-1:0]   r_peak_vld;
  logic [7:0]         r_peak_mem [NBINS];
  logic               r_h_v   [0:2];
  logic [BIN_W-1:0]   r_h_bin [0:2];
  logic [7:0]         r_h_val [0:2];
  logic               r_emit;
  logic [SC_W-1:0]    r_sweep_cnt;

  logic [W-1:0]       w_re, w_im, w_abs_re, w_abs_im, w_max, w_min, w_mag;
  logic               w_accept;
  logic [3:0]         w_lead, w_mant;
  logic [W+2:0]       w_ext;
  logic [7:0]         w_code, w_old, w_dec, w_new;
  logic               w_first, w_last, w_emit_now;
  logic [COL_W-1:0]   w_col;

  // Stage 1: drop undisplayed bins, take magnitudes (-2^(W-1) maps to 2^(W-1))
  assign w_accept = in_valid && !in_idx[IDX_W-1];
  assign w_re     = in_data[2*W-1:W];
  assign w_im     = in_data[W-1:0];
  assign w_abs_re = w_re[W-1] ? (~w_re + W'(1)) : w_re;
  assign w_abs_im = w_im[W-1] ? (~w_im + W'(1)) : w_im;

  // Stage 2: alpha-max-plus-beta-min magnitude estimate
  assign w_max = (r_s1_are >= r_s1_aim) ? r_s1_are : r_s1_aim;
  assign w_min = (r_s1_are >= r_s1_aim) ? r_s1_aim : r_s1_are;
  assign w_mag = w_max + (w_min >> 2) + (w_min >> 3);

  // Stage 3: pseudo-log code {exponent, 4 mantissa bits below the leading one}
  assign w_ext = {r_s2_mag[W-2:0], 4'b0000};
  always_comb begin
    w_lead = 4'd0;
    w_mant = 4'd0;
    for (int i = 0; i < W; i++) begin
      if (r_s2_mag[i]) begin
        w_lead = 4'(i);
        w_mant = w_ext[i+3 -: 4];
      end
    end
    w_code = (r_s2_mag == '0) ? 8'h00 : {w_lead, w_mant};
  end

  // Stage 4: peak hold; the newest in-flight write for this bin overrides the RAM read
  always_comb begin
    w_old = r_peak_vld[r_s3_bin] ? r_s3_peak : 8'h00;
    for (int k = 2; k >= 0; k--) begin
      if (r_h_v[k] && (r_h_bin[k] == r_s3_bin)) begin
        w_old = r_h_val[k];
      end
    end
    w_dec = (w_old > C_DECAY) ? (w_old - C_DECAY) : 8'h00;
    w_new = (r_s3_code > w_dec) ? r_s3_code : w_dec;
  end

  assign w_first    = r_s3_v && (r_s3_bin == '0);
  assign w_last     = r_s3_v && (r_s3_bin == C_LAST_BIN);
  assign w_emit_now = w_first ? ((r_sweep_cnt == '0) && !freeze) : r_emit;
  // col_idx advances one cycle after column_done, so an immediately following column must look ahead
  assign w_col      = column_done ? (col_idx + COL_W'(1)) : col_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_v      <= 1'b0;
      r_s2_v      <= 1'b0;
      r_s3_v      <= 1'b0;
      r_peak_vld  <= '0;
      r_h_v[0]    <= 1'b0;
      r_h_v[1]    <= 1'b0;
      r_h_v[2]    <= 1'b0;
      r_emit      <= 1'b0;
      r_sweep_cnt <= '0;
      pix_wr_en   <= 1'b0;
      pix_wr_addr <= '0;
      pix_wr_data <= 8'h00;
      column_done <= 1'b0;
      col_idx     <= '0;
    end else begin
      r_s1_v      <= w_accept;
      r_s2_v      <= r_s1_v;
      r_s3_v      <= r_s2_v;
      r_h_v[0]    <= r_s3_v;
      r_h_v[1]    <= r_h_v[0];
      r_h_v[2]    <= r_h_v[1];
      pix_wr_en   <= r_s3_v && w_emit_now;
      column_done <= w_last && w_emit_now;
      if (column_done) begin
        col_idx <= col_idx + COL_W'(1);
      end
      if (r_s3_v) begin
        r_peak_vld[r_s3_bin] <= 1'b1;
        pix_wr_addr          <= {w_col, r_s3_bin};
        pix_wr_data          <= w_new;
      end
      if (w_first) begin
        r_emit <= w_emit_now;
      end
      if (w_last) begin
        r_emit      <= 1'b0;
        r_sweep_cnt <= (r_sweep_cnt == C_SC_LAST) ? '0 : (r_sweep_cnt + SC_W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_peak <= r_peak_mem[in_idx[BIN_W-1:0]];
    end
    r_s1_bin   <= in_idx[BIN_W-1:0];
    r_s1_are   <= w_abs_re;
    r_s1_aim   <= w_abs_im;
    r_s2_bin   <= r_s1_bin;
    r_s2_mag   <= w_mag;
    r_s2_peak  <= r_s1_peak;
    r_s3_bin   <= r_s2_bin;
    r_s3_code  <= w_code;
    r_s3_peak  <= r_s2_peak;
    r_h_bin[0] <= r_s3_bin;
    r_h_bin[1] <= r_h_bin[0];
    r_h_bin[2] <= r_h_bin[1];
    r_h_val[0] <= w_new;
    r_h_val[1] <= r_h_val[0];
    r_h_val[2] <= r_h_val[1];
    if (r_s3_v) begin
      r_peak_mem[r_s3_bin] <= w_new;
    end
  end

endmodule
`default_nettype wire
